// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, EX->MEM field offsets,
// load opcodes and the stall-vector encoding.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int StallBus     = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // EX->MEM field LSB positions (MSB->LSB: pc, ld_op, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result)
  localparam int EX_PC_LSB       = 47;
  localparam int EX_LD_OP_LSB    = 44;
  localparam int EX_RAM_EN       = 43;
  localparam int EX_RAM_WEN_LSB  = 39;
  localparam int EX_SEL_RF_RES   = 38;
  localparam int EX_RF_WE        = 37;
  localparam int EX_RF_WADDR_LSB = 32;
  localparam int EX_RESULT_LSB   = 0;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_op_e;

endpackage

// File: rtl/mem_load_align.sv
// Combinational sub-word load extraction and extension.
// MEM_ADDR_ERR_EN enables the misaligned-load flag; otherwise it is tied 0.
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        ld_op,
  input  logic [1:0]        a,
  input  logic [DATA_W-1:0] rdata_eff,
  output logic [DATA_W-1:0] ld_data,
  output logic              misalign
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]        b_s;
    logic signed [DATA_W-1:0] w_s;
    b_s = b;
    w_s = DATA_W'(b_s);
    return sgn ? w_s : DATA_W'(b);
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0]       h_s;
    logic signed [DATA_W-1:0] w_s;
    h_s = h;
    w_s = DATA_W'(h_s);
    return sgn ? w_s : DATA_W'(h);
  endfunction

  logic [DATA_W-1:0] byte_shift;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  // Halves always come from an aligned pair, so a[0] is ignored here.
  assign byte_shift = rdata_eff >> {a, 3'b000};
  assign sel_byte   = byte_shift[7:0];
  assign sel_half   = rdata_eff[16*a[1] +: 16];

  always_comb begin
    ld_data = rdata_eff;
    case (ld_op)
      LD_B:    ld_data = ext_byte(sel_byte, 1'b1);
      LD_BU:   ld_data = ext_byte(sel_byte, 1'b0);
      LD_H:    ld_data = ext_half(sel_half, 1'b1);
      LD_HU:   ld_data = ext_half(sel_half, 1'b0);
      default: ld_data = rdata_eff;
    endcase
  end

`ifdef MEM_ADDR_ERR_EN
  always_comb begin
    misalign = 1'b0;
    case (ld_op)
      LD_B, LD_BU: misalign = 1'b0;
      LD_H, LD_HU: misalign = a[0];
      default:     misalign = |a;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bus, aligns SRAM load data (held across
// stalls) and drives MEM->WB and MEM->ID buses. MEM_ADDR_ERR_EN enables mem_adel.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_forwarding,
  output logic                    mem_adel
);

  logic [EX_TO_MEM_WD-1:0] r_p1_q, r_p1_d;
  logic                    fresh_p1_q, fresh_p1_d;
  logic [31:0]             rdata_hold_p1_q, rdata_hold_p1_d;
  logic                    unused_stall;

  assign unused_stall = ^{stall[5], stall[2:0]};

  always_comb begin
    r_p1_d          = r_p1_q;
    fresh_p1_d      = 1'b0;
    rdata_hold_p1_d = rdata_hold_p1_q;
    if (stall[3] == Stop && stall[4] == NoStop) begin
      r_p1_d = '0;
    end else if (stall[3] == NoStop) begin
      r_p1_d     = ex_to_mem_bus;
      fresh_p1_d = 1'b1;
    end
    if (fresh_p1_q) rdata_hold_p1_d = data_sram_rdata;
  end

  // EX -> MEM boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_q          <= '0;
      fresh_p1_q      <= 1'b0;
      rdata_hold_p1_q <= '0;
    end else begin
      r_p1_q          <= r_p1_d;
      fresh_p1_q      <= fresh_p1_d;
      rdata_hold_p1_q <= rdata_hold_p1_d;
    end
  end

  logic [31:0] pc, ex_result, rdata_eff, ld_data, rf_wdata;
  logic [2:0]  ld_op;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;
  logic        ram_en, sel_rf_res, rf_we, rf_we_eff, is_load, misalign, adel;

  assign pc         = r_p1_q[EX_PC_LSB +: 32];
  assign ld_op      = r_p1_q[EX_LD_OP_LSB +: 3];
  assign ram_en     = r_p1_q[EX_RAM_EN];
  assign ram_wen    = r_p1_q[EX_RAM_WEN_LSB +: 4];
  assign sel_rf_res = r_p1_q[EX_SEL_RF_RES];
  assign rf_we      = r_p1_q[EX_RF_WE];
  assign rf_waddr   = r_p1_q[EX_RF_WADDR_LSB +: 5];
  assign ex_result  = r_p1_q[EX_RESULT_LSB +: 32];

  // The SRAM presents data only in the cycle after issue; later stall cycles replay the hold copy.
  assign rdata_eff = fresh_p1_q ? data_sram_rdata : rdata_hold_p1_q;

  mem_load_align #(.DATA_W(32)) u_align (
    .ld_op     (ld_op),
    .a         (ex_result[1:0]),
    .rdata_eff (rdata_eff),
    .ld_data   (ld_data),
    .misalign  (misalign)
  );

  assign is_load   = ram_en && (ram_wen == 4'b0000) && sel_rf_res;
  assign adel      = is_load && misalign;
  assign rf_we_eff = rf_we && !adel;
  assign rf_wdata  = sel_rf_res ? ld_data : ex_result;

  assign mem_to_wb_bus        = {pc, rf_we_eff, rf_waddr, rf_wdata};
  assign mem_to_id_forwarding = {rf_we_eff, rf_waddr, rf_wdata};
  assign mem_adel             = adel;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_mem_stage;
  import mem_stage_pkg::*;

`ifdef MEM_ADDR_ERR_EN
  localparam logic ADE = 1'b1;
`else
  localparam logic ADE = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [StallBus-1:0]     stall = '0;
  logic [EX_TO_MEM_WD-1:0] ex_bus = '0;
  logic [31:0]             rdata = '0;
  logic [MEM_TO_WB_WD-1:0] wb_bus;
  logic [MEM_TO_ID_WD-1:0] id_bus;
  logic                    adel;

  mem_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .ex_to_mem_bus        (ex_bus),
    .data_sram_rdata      (rdata),
    .mem_to_wb_bus        (wb_bus),
    .mem_to_id_forwarding (id_bus),
    .mem_adel             (adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MEM_TO_WB_WD-1:0] wb;
    logic [MEM_TO_ID_WD-1:0] id;
    logic                    adel;
    string                   name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [EX_TO_MEM_WD-1:0] mk(
    input logic [31:0] pc, input logic [2:0] op, input logic en, input logic [3:0] wen,
    input logic sel, input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {pc, op, en, wen, sel, we, wa, res};
  endfunction

  // Drive inputs for the next edge and record what the outputs must be right now.
  task automatic step(
    input logic r, input logic [5:0] st, input logic [EX_TO_MEM_WD-1:0] nb,
    input logic [31:0] rd, input logic chk,
    input logic [31:0] e_pc, input logic e_we, input logic [4:0] e_wa,
    input logic [31:0] e_wd, input logic e_adel, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    stall  = st;
    ex_bus = nb;
    rdata  = rd;
    if (chk) begin
      e.wb   = {e_pc, e_we, e_wa, e_wd};
      e.id   = {e_we, e_wa, e_wd};
      e.adel = e_adel;
      e.name = nm;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (wb_bus !== e.wb) begin
        n_fail++;
        $display("FAIL %s.wb got %h expected %h", e.name, wb_bus, e.wb);
      end
      n_chk++;
      if (id_bus !== e.id) begin
        n_fail++;
        $display("FAIL %s.id got %h expected %h", e.name, id_bus, e.id);
      end
      n_chk++;
      if (adel !== e.adel) begin
        n_fail++;
        $display("FAIL %s.adel got %b expected %b", e.name, adel, e.adel);
      end
    end
  end

  logic [EX_TO_MEM_WD-1:0] b_lb, b_lbu, b_lh, b_lhu, b_lw, b_alu, b_st, b_lh1, b_lw2, b_lb3, b_lbu0, b_lw5;

  initial begin
    b_lb   = mk(32'h100, 3'd1, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3,  32'h1001);
    b_lbu  = mk(32'h104, 3'd2, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4,  32'h1001);
    b_lh   = mk(32'h108, 3'd3, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5,  32'h1002);
    b_lhu  = mk(32'h10C, 3'd4, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6,  32'h1002);
    b_lw   = mk(32'h110, 3'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8,  32'h2000);
    b_alu  = mk(32'h114, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9,  32'h1234);
    b_st   = mk(32'h118, 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0,  32'h0300);
    b_lh1  = mk(32'h11C, 3'd3, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h2001);
    b_lw2  = mk(32'h120, 3'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h3002);
    b_lb3  = mk(32'h124, 3'd1, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h4003);
    b_lbu0 = mk(32'h128, 3'd2, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h4004);
    b_lw5  = mk(32'h12C, 3'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd14, 32'h5000);

    //    rst   stall      next bus  rdata         chk   pc        we    wa     wdata         adel
    step(1'b1, 6'b000000, '0,     32'h0,         1'b0, 32'h0,   1'b0, 5'd0,  32'h0,        1'b0, "pre");
    step(1'b0, 6'b000000, b_lb,   32'h0,         1'b1, 32'h0,   1'b0, 5'd0,  32'h0,        1'b0, "reset");
    step(1'b0, 6'b000000, b_lbu,  32'h1234_80FF, 1'b1, 32'h100, 1'b1, 5'd3,  32'hFFFF_FF80, 1'b0, "lb");
    step(1'b0, 6'b000000, b_lh,   32'h1234_80FF, 1'b1, 32'h104, 1'b1, 5'd4,  32'h0000_0080, 1'b0, "lbu");
    step(1'b0, 6'b000000, b_lhu,  32'h8001_0000, 1'b1, 32'h108, 1'b1, 5'd5,  32'hFFFF_8001, 1'b0, "lh");
    step(1'b0, 6'b000000, b_lw,   32'h8001_0000, 1'b1, 32'h10C, 1'b1, 5'd6,  32'h0000_8001, 1'b0, "lhu");
    step(1'b0, 6'b011000, b_alu,  32'hDEAD_BEEF, 1'b1, 32'h110, 1'b1, 5'd8,  32'hDEAD_BEEF, 1'b0, "lw_fresh");
    step(1'b0, 6'b011000, b_alu,  32'h0,         1'b1, 32'h110, 1'b1, 5'd8,  32'hDEAD_BEEF, 1'b0, "lw_hold1");
    step(1'b0, 6'b001000, b_alu,  32'h0,         1'b1, 32'h110, 1'b1, 5'd8,  32'hDEAD_BEEF, 1'b0, "lw_hold2");
    step(1'b0, 6'b000000, b_alu,  32'h5555_5555, 1'b1, 32'h0,   1'b0, 5'd0,  32'h0,        1'b0, "bubble");
    step(1'b0, 6'b000000, b_st,   32'hFFFF_FFFF, 1'b1, 32'h114, 1'b1, 5'd9,  32'h0000_1234, 1'b0, "alu");
    step(1'b0, 6'b000000, b_lh1,  32'hFFFF_FFFF, 1'b1, 32'h118, 1'b0, 5'd0,  32'h0000_0300, 1'b0, "store");
    step(1'b0, 6'b000000, b_lw2,  32'h1234_8001, 1'b1, 32'h11C, !ADE, 5'd10, 32'hFFFF_8001, ADE,  "lh_misalign");
    step(1'b0, 6'b000000, b_lb3,  32'hCAFE_F00D, 1'b1, 32'h120, !ADE, 5'd11, 32'hCAFE_F00D, ADE,  "lw_misalign");
    step(1'b0, 6'b000000, b_lbu0, 32'h7F00_0000, 1'b1, 32'h124, 1'b1, 5'd12, 32'h0000_007F, 1'b0, "lb_b2b");
    step(1'b0, 6'b000000, b_lw5,  32'h1234_56AB, 1'b1, 32'h128, 1'b1, 5'd13, 32'h0000_00AB, 1'b0, "lbu_b2b");
    step(1'b1, 6'b011000, b_alu,  32'h1111_1111, 1'b1, 32'h12C, 1'b1, 5'd14, 32'h1111_1111, 1'b0, "lw_pre_rst");
    step(1'b0, 6'b000000, '0,     32'h2222_2222, 1'b1, 32'h0,   1'b0, 5'd0,  32'h0,        1'b0, "rst_mid_stall");
    step(1'b0, 6'b000000, '0,     32'h0,         1'b1, 32'h0,   1'b0, 5'd0,  32'h0,        1'b0, "idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
